// File: rtl/scarv_rom_arbiter_if.sv
// scarv_rom_arbiter_if: requester buses and ROM macro signals shared by the arbiter
interface scarv_rom_arbiter_if #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
);
  logic                     p0_req;
  logic                     p0_gnt;
  logic                     p0_wen;
  logic [31:0]              p0_addr;
  logic                     p0_rsp_valid;
  logic                     p0_rsp_ready;
  logic [WIDTH-1:0]         p0_rdata;
  logic                     p0_error;
  logic                     p1_req;
  logic                     p1_gnt;
  logic                     p1_wen;
  logic [31:0]              p1_addr;
  logic                     p1_rsp_valid;
  logic                     p1_rsp_ready;
  logic [WIDTH-1:0]         p1_rdata;
  logic                     p1_error;
  logic                     rom_cen;
  logic [$clog2(DEPTH)-1:0] rom_addr;
  logic [WIDTH-1:0]         rom_rdata;
  modport master (
    output p0_req, p0_wen, p0_addr, p0_rsp_ready,
    output p1_req, p1_wen, p1_addr, p1_rsp_ready,
    output rom_rdata,
    input  p0_gnt, p0_rsp_valid, p0_rdata, p0_error,
    input  p1_gnt, p1_rsp_valid, p1_rdata, p1_error,
    input  rom_cen, rom_addr
  );
  modport slave (
    input  p0_req, p0_wen, p0_addr, p0_rsp_ready,
    input  p1_req, p1_wen, p1_addr, p1_rsp_ready,
    input  rom_rdata,
    output p0_gnt, p0_rsp_valid, p0_rdata, p0_error,
    output p1_gnt, p1_rsp_valid, p1_rdata, p1_error,
    output rom_cen, rom_addr
  );
endinterface

// File: rtl/scarv_rom_arbiter.sv
// scarv_rom_arbiter: round-robin sharing of a one-cycle read-only ROM between fetch and load ports
module scarv_rom_arbiter #(
  parameter int          DEPTH = 1024,
  parameter int          WIDTH = 32,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input logic                g_clk,
  input logic                g_reset,
  scarv_rom_arbiter_if.slave bus
);
  localparam int         BW   = WIDTH / 8;
  localparam int         OFF  = $clog2(BW);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [32:0] SIZE = 33'(DEPTH) * 33'(BW);
  typedef enum logic [1:0] {IDLE, FRESH, HELD, ERR} st_t;
  logic [1:0]       req, wen, rdy, valid, el, bad, gnt, good;
  logic [31:0]      addr [2];
  logic [AW-1:0]    wa [2];
  logic             ptr_q, ptr_d;
  assign req     = {bus.p1_req, bus.p0_req};
  assign wen     = {bus.p1_wen, bus.p0_wen};
  assign rdy     = {bus.p1_rsp_ready, bus.p0_rsp_ready};
  assign addr[0] = bus.p0_addr;
  assign addr[1] = bus.p1_addr;
  for (genvar n = 0; n < 2; n++) begin : g_port
    st_t              st_q, st_d;
    logic [WIDTH-1:0] hold_q, hold_d, rd;
    logic [32:0]      off;
    assign off      = {1'b0, addr[n]} - {1'b0, BASE};
    assign bad[n]   = wen[n] | (off >= SIZE) | ((addr[n] & 32'(BW - 1)) != 32'd0);
    assign wa[n]    = AW'(off[31:0] >> OFF);
    assign valid[n] = st_q != IDLE;
    assign el[n]    = req[n] & ~g_reset & (~valid[n] | rdy[n]);
    assign rd       = st_q == FRESH ? bus.rom_rdata : st_q == HELD ? hold_q : '0;
    // A fresh grant wins over retirement; an unaccepted fresh read parks its data in the hold register
    always_comb begin
      st_d   = gnt[n] ? (bad[n] ? ERR : FRESH) : (valid[n] & rdy[n]) ? IDLE : st_q == FRESH ? HELD : st_q;
      hold_d = st_q == FRESH ? bus.rom_rdata : hold_q;
    end
    // Per-port response state and hold register
    always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
        st_q   <= IDLE;
        hold_q <= '0;
      end else begin
        st_q   <= st_d;
        hold_q <= hold_d;
      end
    end
  end
  assign gnt[0]       = el[0] & (~el[1] | ~ptr_q);
  assign gnt[1]       = el[1] & (~el[0] | ptr_q);
  assign good         = gnt & ~bad;
  assign bus.p0_gnt   = gnt[0];
  assign bus.p1_gnt   = gnt[1];
  assign bus.rom_cen  = |good;
  assign bus.rom_addr = good[0] ? wa[0] : good[1] ? wa[1] : '0;
  assign bus.p0_rsp_valid = valid[0];
  assign bus.p1_rsp_valid = valid[1];
  assign bus.p0_error = g_port[0].st_q == ERR;
  assign bus.p1_error = g_port[1].st_q == ERR;
  assign bus.p0_rdata = g_port[0].rd;
  assign bus.p1_rdata = g_port[1].rd;
  // Priority pointer moves to the port that was not just granted
  always_comb ptr_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : ptr_q;
  // Priority pointer register; port 0 favoured out of reset
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: tb/tb_scarv_rom_arbiter.sv
// tb_scarv_rom_arbiter: directed checks of arbitration, stalls, errors and reset
module tb_scarv_rom_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  scarv_rom_arbiter_if #(.DEPTH(1024), .WIDTH(32)) bus ();
  scarv_rom_arbiter #(.DEPTH(1024), .WIDTH(32), .BASE(32'h0)) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .bus     (bus)
  );
  // ROM macro model: word i holds 0x1000_0000 + i, one-cycle read latency
  always @(posedge clk) if (bus.rom_cen) bus.rom_rdata <= 32'h1000_0000 + 32'(bus.rom_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic err_case(input string tag, input logic w, input logic [31:0] a);
    bus.p0_req = 1'b1; bus.p0_wen = w; bus.p0_addr = a;
    mid;
    chk({tag, "_gnt"}, bus.p0_gnt, 1);
    chk({tag, "_cen"}, bus.rom_cen, 0);
    chk({tag, "_raddr"}, bus.rom_addr, 0);
    nxt;
    bus.p0_req = 1'b0; bus.p0_wen = 1'b0;
    mid;
    chk({tag, "_valid"}, bus.p0_rsp_valid, 1);
    chk({tag, "_error"}, bus.p0_error, 1);
    chk({tag, "_rdata"}, bus.p0_rdata, 0);
    nxt;
    mid;
    chk({tag, "_done"}, bus.p0_rsp_valid, 0);
    nxt;
  endtask
  initial begin
    bus.p0_req = 1'b1; bus.p0_wen = 1'b0; bus.p0_addr = 32'h0; bus.p0_rsp_ready = 1'b1;
    bus.p1_req = 1'b0; bus.p1_wen = 1'b0; bus.p1_addr = 32'h0; bus.p1_rsp_ready = 1'b1;
    mid;
    chk("rst_gnt0", bus.p0_gnt, 0);
    chk("rst_gnt1", bus.p1_gnt, 0);
    chk("rst_cen", bus.rom_cen, 0);
    chk("rst_raddr", bus.rom_addr, 0);
    chk("rst_v0", bus.p0_rsp_valid, 0);
    chk("rst_v1", bus.p1_rsp_valid, 0);
    chk("rst_d0", bus.p0_rdata, 0);
    chk("rst_e0", bus.p0_error, 0);
    nxt;
    rst = 1'b0;
    bus.p0_addr = 32'h8;
    mid;
    chk("single_gnt0", bus.p0_gnt, 1);
    chk("single_cen", bus.rom_cen, 1);
    chk("single_raddr", bus.rom_addr, 2);
    nxt;
    bus.p0_req = 1'b0;
    mid;
    chk("single_valid", bus.p0_rsp_valid, 1);
    chk("single_rdata", bus.p0_rdata, 32'h1000_0002);
    chk("single_err", bus.p0_error, 0);
    chk("single_cen_off", bus.rom_cen, 0);
    nxt;
    mid;
    chk("single_done", bus.p0_rsp_valid, 0);
    nxt;
    bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
    bus.p1_req = 1'b1; bus.p1_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      mid;
      chk("cont_gnt0", bus.p0_gnt, k % 2);
      chk("cont_gnt1", bus.p1_gnt, (k + 1) % 2);
      chk("cont_raddr", bus.rom_addr, (k % 2) != 0 ? 4 : 8);
      if (k > 0) begin
        chk("cont_v0", bus.p0_rsp_valid, (k + 1) % 2);
        chk("cont_v1", bus.p1_rsp_valid, k % 2);
        if ((k % 2) != 0) chk("cont_d1", bus.p1_rdata, 32'h1000_0008);
        else chk("cont_d0", bus.p0_rdata, 32'h1000_0004);
      end
      nxt;
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    mid;
    chk("cont_last_v0", bus.p0_rsp_valid, 1);
    chk("cont_last_d0", bus.p0_rdata, 32'h1000_0004);
    chk("cont_last_v1", bus.p1_rsp_valid, 0);
    nxt;
    bus.p0_req = 1'b1; bus.p0_addr = 32'h14; bus.p0_rsp_ready = 1'b0;
    mid;
    chk("stall_gnt0", bus.p0_gnt, 1);
    chk("stall_raddr", bus.rom_addr, 5);
    nxt;
    bus.p0_addr = 32'h0;
    bus.p1_req = 1'b1; bus.p1_addr = 32'h18;
    mid;
    chk("stall_b_gnt0", bus.p0_gnt, 0);
    chk("stall_b_gnt1", bus.p1_gnt, 1);
    chk("stall_b_raddr", bus.rom_addr, 6);
    chk("stall_b_d0", bus.p0_rdata, 32'h1000_0005);
    nxt;
    bus.p1_addr = 32'h1C;
    mid;
    chk("stall_c_gnt0", bus.p0_gnt, 0);
    chk("stall_c_gnt1", bus.p1_gnt, 1);
    chk("stall_c_raddr", bus.rom_addr, 7);
    chk("stall_c_v0", bus.p0_rsp_valid, 1);
    chk("stall_c_d0", bus.p0_rdata, 32'h1000_0005);
    chk("stall_c_d1", bus.p1_rdata, 32'h1000_0006);
    nxt;
    bus.p1_req = 1'b0;
    mid;
    chk("stall_d_gnt0", bus.p0_gnt, 0);
    chk("stall_d_d0", bus.p0_rdata, 32'h1000_0005);
    chk("stall_d_d1", bus.p1_rdata, 32'h1000_0007);
    nxt;
    mid;
    chk("stall_e_gnt0", bus.p0_gnt, 0);
    chk("stall_e_v0", bus.p0_rsp_valid, 1);
    chk("stall_e_d0", bus.p0_rdata, 32'h1000_0005);
    nxt;
    bus.p0_rsp_ready = 1'b1;
    mid;
    chk("stall_f_gnt0", bus.p0_gnt, 1);
    chk("stall_f_raddr", bus.rom_addr, 0);
    chk("stall_f_d0", bus.p0_rdata, 32'h1000_0005);
    nxt;
    bus.p0_req = 1'b0;
    mid;
    chk("stall_g_v0", bus.p0_rsp_valid, 1);
    chk("stall_g_d0", bus.p0_rdata, 32'h1000_0000);
    nxt;
    err_case("err_wen", 1'b1, 32'h4);
    err_case("err_range", 1'b0, 32'h1000);
    err_case("err_align", 1'b0, 32'h2);
    for (int i = 0; i < 16; i++) begin
      bus.p1_req = 1'b1; bus.p1_addr = 32'((i + 16) * 4);
      mid;
      chk("b2b_gnt1", bus.p1_gnt, 1);
      chk("b2b_raddr", bus.rom_addr, 32'(i + 16));
      if (i > 0) begin
        chk("b2b_v1", bus.p1_rsp_valid, 1);
        chk("b2b_d1", bus.p1_rdata, 32'h1000_0000 + 32'(i + 15));
      end
      nxt;
    end
    bus.p1_req = 1'b0;
    mid;
    chk("b2b_last_v1", bus.p1_rsp_valid, 1);
    chk("b2b_last_d1", bus.p1_rdata, 32'h1000_001F);
    nxt;
    bus.p1_req = 1'b1; bus.p1_addr = 32'h24; bus.p1_rsp_ready = 1'b0;
    nxt;
    bus.p1_req = 1'b0;
    bus.p0_req = 1'b1; bus.p0_addr = 32'h28;
    mid;
    chk("rsth_gnt0", bus.p0_gnt, 1);
    nxt;
    bus.p0_req = 1'b0;
    mid;
    chk("rsth_v1", bus.p1_rsp_valid, 1);
    chk("rsth_d1", bus.p1_rdata, 32'h1000_0009);
    #1;
    bus.p0_req = 1'b1; bus.p0_addr = 32'h0;
    bus.p1_req = 1'b1; bus.p1_addr = 32'h4;
    rst = 1'b1;
    #1;
    chk("rsta_v1", bus.p1_rsp_valid, 0);
    chk("rsta_d1", bus.p1_rdata, 0);
    chk("rsta_v0", bus.p0_rsp_valid, 0);
    chk("rsta_gnt0", bus.p0_gnt, 0);
    chk("rsta_gnt1", bus.p1_gnt, 0);
    chk("rsta_cen", bus.rom_cen, 0);
    chk("rsta_raddr", bus.rom_addr, 0);
    nxt;
    rst = 1'b0;
    bus.p1_rsp_ready = 1'b1;
    mid;
    chk("rstr_gnt0", bus.p0_gnt, 1);
    chk("rstr_gnt1", bus.p1_gnt, 0);
    nxt;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    nxt;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
